avl_bus_pipe: RTL and testbench
===============================

// Module: avl_bus_pipe
// PURPOSE
//  Parametrised Avalon-style register slice between one bus master and one slave.
//  Cuts every combinational path of the request and response channels (incl. request_ready).
//  Request path uses a 2-entry skid buffer; read-response path uses a RESP_DEPTH FIFO.
//  Placed between interconnect stages or in front of the SDRAM/HDMI frame-buffer ports.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  write_data/read_data width; must be a multiple of 8
//  BURST_W      8  burst_count width
//  RESP_DEPTH   4  read-response FIFO entries; power of 2, >= 2
// PORTS
//  clk                   in   1          single clock
//  rst                   in   1          reset, asynchronous, active-high
//  s_address             in   ADDR_W     upstream request (s_ = facing master)
//  s_byte_en             in   DATA_W/8
//  s_read / s_write      in   1 / 1
//  s_write_data          in   DATA_W
//  s_begin_burst_transfer in  1          first beat of a burst
//  s_burst_count         in   BURST_W
//  s_request_ready       out  1
//  s_read_data           out  DATA_W
//  s_read_data_valid     out  1
//  s_resp_ready          in   1
//  m_*                   -    -          same set, directions mirrored, facing the slave
//  stat_rd_beats         out  32         only with AVL_PIPE_STATS_EN
//  stat_wr_beats         out  32         only with AVL_PIPE_STATS_EN
// BEHAVIOUR
//  Handshakes: request beat accepted when (read|write) && request_ready.
//   Response beat accepted when read_data_valid && resp_ready.
//  Request payload = {address, byte_en, read, write, write_data, begin_burst, burst_count},
//   carried unchanged as one word; begin_burst stays tied to its own beat.
//  Skid FSM: EMPTY -> ONE on accept; ONE -> TWO on accept with m stalled;
//   TWO -> ONE on m accept; ONE -> EMPTY on m accept with no s accept.
//   ONE with simultaneous accepts stays ONE, output register reloaded.
//  s_request_ready = !skid_valid, from a flop only. No bypass.
//  Request latency: 1 cycle, full throughput.
//  m_read/m_write asserted only in ONE/TWO; other m_ request fields hold until accepted.
//  Resp FIFO: push = m_read_data_valid && m_resp_ready; pop = s_read_data_valid && s_resp_ready.
//   m_resp_ready = (count != RESP_DEPTH).
//   s_read_data_valid = (count != 0); s_read_data = head entry.
//   Full: push blocked, pop allowed. Empty: no pass-through; response latency is 1 cycle.
//   Pointers wrap modulo RESP_DEPTH; count width $clog2(RESP_DEPTH)+1.
//  Beat order preserved on both channels. No reordering and no write response.
//  Reset values: s_request_ready 1, all valids 0, m_read/m_write 0, data outputs 0,
//   count/pointers 0, FSM EMPTY, stats 0.
//  Reset mid-burst: all buffered beats are discarded. The master must reissue the burst.
// CONFIGURATION
//  AVL_PIPE_STATS_EN defined: stat_rd_beats counts m-side accepted read requests;
//   stat_wr_beats counts m-side accepted write beats. Both are 32-bit, wrap at 2^32,
//   and are cleared only by rst.
//  Undefined: the stat ports and counters do not exist. Other behaviour is identical.
// STRUCTURE
//  Package avl_pkg: default widths AVL_ADDR_W/AVL_DATA_W/AVL_BURST_W,
//   typedef enum skid_state_e {EMPTY, ONE, TWO},
//   function avl_req_width(addr_w, data_w, burst_w).
//  Sub-module avl_resp_fifo (DATA_W, RESP_DEPTH): registered-output FIFO with count.
//  The skid buffer stays inline. An i_avl_bus wrapper binds the 32/8 defaults.
// TESTING
//  1. Single write 0x10/0xDEADBEEF, m_request_ready=1: appears on m_ 1 cycle later;
//     s_request_ready stays 1.
//  2. m_request_ready=0 for 5 cycles during back-to-back writes: s_request_ready drops
//     after 2 beats; 0 beats lost or duplicated after release.
//  3. 8-beat read burst with s_resp_ready=0: m_resp_ready drops after 4 data beats;
//     all 8 data words delivered in order once resp_ready=1.
//  4. Same-cycle push and pop at count=2: count stays 2; data order intact.
//  5. rst asserted mid-burst with TWO buffered and FIFO count=3: outputs reach their
//     reset values asynchronously; s_request_ready=1 in the first cycle after release.
//  6. AVL_PIPE_STATS_EN: 3 reads plus a 4-beat write burst -> stat_rd_beats=3,
//     stat_wr_beats=4.

Source files
------------

// File: rtl/avl_pkg.sv
// Shared definitions for the Avalon-style bus register slice.
//   AVL_ADDR_W / AVL_DATA_W / AVL_BURST_W : default widths (32/32/8)
//   skid_state_e                          : occupancy of the request skid buffer
//   avl_req_width()                       : width of the packed request word
package avl_pkg;

    localparam int AVL_ADDR_W  = 32;
    localparam int AVL_DATA_W  = 32;
    localparam int AVL_BURST_W = 8;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_e;

    // Request word layout, MSB first:
    // {address, byte_en, read, write, write_data, begin_burst, burst_count}
    function automatic int avl_req_width(input int addr_w, input int data_w, input int burst_w);
        return addr_w + data_w / 8 + 2 + data_w + 1 + burst_w;
    endfunction

endpackage

// File: rtl/avl_resp_fifo.sv
// Read-response FIFO of the bus register slice.
// The pop side is driven only from flops (count, read pointer, storage), and
// the push-side ready depends only on the count, so no combinational path
// crosses the FIFO in either direction. An empty FIFO shows zero data.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push_valid    : write-side beat offered
//   i_push_data     : write-side data
//   o_push_ready    : FIFO not full
//   o_pop_valid     : FIFO not empty
//   o_pop_data      : head entry (zero when empty)
//   i_pop_ready     : read side takes the head entry
module avl_resp_fifo
    import avl_pkg::*;
#(
    parameter int DATA_W = AVL_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push_valid,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_push_ready,
    output logic              o_pop_valid,
    output logic [DATA_W-1:0] o_pop_data,
    input  logic              i_pop_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_push_ready = (r_count != CNT_W'(DEPTH));
    assign o_pop_valid  = (r_count != '0);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    // Storage carries no reset; the empty case is masked to zero at the output.
    assign o_pop_data = o_pop_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avl_bus_pipe.sv
// Avalon-style register slice between one bus master (s_ side) and one slave
// (m_ side). Every request and response output comes from a flop: requests go
// through a 2-entry skid buffer (output register + skid register), read data
// through avl_resp_fifo. One cycle latency, full throughput, order preserved.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   s_address .. s_burst_count    : request from master
//   s_request_ready               : request accepted when (read|write) && ready
//   s_read_data/_valid, s_resp_ready : response to master
//   m_address .. m_burst_count    : request to slave (held until accepted)
//   m_request_ready               : slave accepts request
//   m_read_data/_valid, m_resp_ready : response from slave
//   stat_rd_beats, stat_wr_beats  : accepted m-side read/write beat counters,
//                                   present only when AVL_PIPE_STATS_EN is defined
module avl_bus_pipe
    import avl_pkg::*;
#(
    parameter int ADDR_W     = AVL_ADDR_W,
    parameter int DATA_W     = AVL_DATA_W,
    parameter int BURST_W    = AVL_BURST_W,
    parameter int RESP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [DATA_W/8-1:0] s_byte_en,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_write_data,
    input  logic                s_begin_burst_transfer,
    input  logic [BURST_W-1:0]  s_burst_count,
    output logic                s_request_ready,
    output logic [DATA_W-1:0]   s_read_data,
    output logic                s_read_data_valid,
    input  logic                s_resp_ready,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byte_en,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_write_data,
    output logic                m_begin_burst_transfer,
    output logic [BURST_W-1:0]  m_burst_count,
    input  logic                m_request_ready,
    input  logic [DATA_W-1:0]   m_read_data,
    input  logic                m_read_data_valid,
    output logic                m_resp_ready
`ifdef AVL_PIPE_STATS_EN
    ,
    output logic [31:0]         stat_rd_beats,
    output logic [31:0]         stat_wr_beats
`endif
);

    localparam int REQ_W  = avl_req_width(ADDR_W, DATA_W, BURST_W);
    localparam int WR_BIT = BURST_W + DATA_W + 1;
    localparam int RD_BIT = BURST_W + DATA_W + 2;

    skid_state_e      r_state;
    logic [REQ_W-1:0] r_out_req;
    logic [REQ_W-1:0] r_skid_req;
    logic             r_s_ready;
    logic [REQ_W-1:0] w_s_req;
    logic             w_s_acc;
    logic             w_m_acc;

    assign w_s_req = {s_address, s_byte_en, s_read, s_write, s_write_data,
                      s_begin_burst_transfer, s_burst_count};

    assign {m_address, m_byte_en, m_read, m_write, m_write_data,
            m_begin_burst_transfer, m_burst_count} = r_out_req;

    assign s_request_ready = r_s_ready;
    assign w_s_acc         = (s_read || s_write) && r_s_ready;
    assign w_m_acc         = (m_read || m_write) && m_request_ready;

    // The output register presents the oldest beat; the skid register only
    // fills when a beat arrives while the slave stalls. Ready is the inverse
    // of skid occupancy and is kept in its own flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_out_req  <= '0;
            r_skid_req <= '0;
            r_s_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_s_acc) begin
                        r_out_req <= w_s_req;
                        r_state   <= ONE;
                    end
                end
                ONE: begin
                    if (w_s_acc && w_m_acc) begin
                        r_out_req <= w_s_req;
                    end else if (w_s_acc) begin
                        r_skid_req <= w_s_req;
                        r_state    <= TWO;
                        r_s_ready  <= 1'b0;
                    end else if (w_m_acc) begin
                        // Drop the strobes but hold the remaining fields.
                        r_out_req[RD_BIT] <= 1'b0;
                        r_out_req[WR_BIT] <= 1'b0;
                        r_state           <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_m_acc) begin
                        r_out_req <= r_skid_req;
                        r_state   <= ONE;
                        r_s_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    r_s_ready <= 1'b1;
                end
            endcase
        end
    end

    avl_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (m_read_data_valid),
        .i_push_data  (m_read_data),
        .o_push_ready (m_resp_ready),
        .o_pop_valid  (s_read_data_valid),
        .o_pop_data   (s_read_data),
        .i_pop_ready  (s_resp_ready)
    );

`ifdef AVL_PIPE_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;

    // A read request counts once regardless of its burst length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            r_stat_rd <= r_stat_rd + 32'(w_m_acc && m_read);
            r_stat_wr <= r_stat_wr + 32'(w_m_acc && m_write);
        end
    end

    assign stat_rd_beats = r_stat_rd;
    assign stat_wr_beats = r_stat_wr;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_avl_bus_pipe.sv
module tb_avl_bus_pipe;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 8;
    localparam int BE_W    = DATA_W / 8;
    localparam int REQ_W   = ADDR_W + BE_W + 2 + DATA_W + 1 + BURST_W;
    localparam int DEPTH   = 4;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   s_address;
    logic [BE_W-1:0]     s_byte_en;
    logic                s_read;
    logic                s_write;
    logic [DATA_W-1:0]   s_write_data;
    logic                s_begin_burst_transfer;
    logic [BURST_W-1:0]  s_burst_count;
    logic                s_request_ready;
    logic [DATA_W-1:0]   s_read_data;
    logic                s_read_data_valid;
    logic                s_resp_ready;
    logic [ADDR_W-1:0]   m_address;
    logic [BE_W-1:0]     m_byte_en;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_write_data;
    logic                m_begin_burst_transfer;
    logic [BURST_W-1:0]  m_burst_count;
    logic                m_request_ready;
    logic [DATA_W-1:0]   m_read_data;
    logic                m_read_data_valid;
    logic                m_resp_ready;
`ifdef AVL_PIPE_STATS_EN
    logic [31:0]         stat_rd_beats;
    logic [31:0]         stat_wr_beats;
`endif

    avl_bus_pipe dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_address              (s_address),
        .s_byte_en              (s_byte_en),
        .s_read                 (s_read),
        .s_write                (s_write),
        .s_write_data           (s_write_data),
        .s_begin_burst_transfer (s_begin_burst_transfer),
        .s_burst_count          (s_burst_count),
        .s_request_ready        (s_request_ready),
        .s_read_data            (s_read_data),
        .s_read_data_valid      (s_read_data_valid),
        .s_resp_ready           (s_resp_ready),
        .m_address              (m_address),
        .m_byte_en              (m_byte_en),
        .m_read                 (m_read),
        .m_write                (m_write),
        .m_write_data           (m_write_data),
        .m_begin_burst_transfer (m_begin_burst_transfer),
        .m_burst_count          (m_burst_count),
        .m_request_ready        (m_request_ready),
        .m_read_data            (m_read_data),
        .m_read_data_valid      (m_read_data_valid),
        .m_resp_ready           (m_resp_ready)
`ifdef AVL_PIPE_STATS_EN
        ,
        .stat_rd_beats          (stat_rd_beats),
        .stat_wr_beats          (stat_wr_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: requests accepted but not yet taken by the slave,
    // responses accepted but not yet delivered, and delivered responses.
    logic [REQ_W-1:0]  req_q[$];
    logic [DATA_W-1:0] resp_q[$];
    logic [DATA_W-1:0] delivered_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REQ_W-1:0] pack_s();
        return {s_address, s_byte_en, s_read, s_write, s_write_data,
                s_begin_burst_transfer, s_burst_count};
    endfunction

    function automatic logic [REQ_W-1:0] pack_m();
        return {m_address, m_byte_en, m_read, m_write, m_write_data,
                m_begin_burst_transfer, m_burst_count};
    endfunction

    // Monitor: samples 1 time unit before each rising edge, when every DUT
    // output and tb input is stable and equals what the edge will see.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            req_q.delete();
            resp_q.delete();
        end else begin
            chk("req_ready", 128'(s_request_ready), 128'(req_q.size() < 2));
            chk("m_valid", 128'(m_read | m_write), 128'(req_q.size() > 0));
            chk("resp_ready", 128'(m_resp_ready), 128'(req_q.size() >= 0 && resp_q.size() != DEPTH));
            chk("s_rvalid", 128'(s_read_data_valid), 128'(resp_q.size() != 0));
            if (resp_q.size() != 0) chk("s_rdata", 128'(s_read_data), 128'(resp_q[0]));
            if ((m_read | m_write) && m_request_ready) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_req: got %0h expected no request at %0t", pack_m(), $time);
                end else begin
                    chk("m_req", 128'(pack_m()), 128'(req_q.pop_front()));
                end
            end
            if ((s_read | s_write) && s_request_ready) req_q.push_back(pack_s());
            if (s_read_data_valid && s_resp_ready && resp_q.size() != 0) begin
                delivered_q.push_back(s_read_data);
                void'(resp_q.pop_front());
            end
            if (m_read_data_valid && m_resp_ready) resp_q.push_back(m_read_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s_wr;
        logic [31:0] wdata;
        logic        m_rdy;
        logic        exp_s_rdy;
        logic        exp_m_wr;
        logic [31:0] exp_m_data;
    } vec_t;

    vec_t vecs[9];

    task automatic idle_inputs();
        s_read = 0; s_write = 0; s_begin_burst_transfer = 0;
        m_read_data_valid = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_req_ready"}, 128'(s_request_ready), 128'(1));
        chk({tag, "_m_read"}, 128'(m_read), 128'(0));
        chk({tag, "_m_write"}, 128'(m_write), 128'(0));
        chk({tag, "_m_address"}, 128'(m_address), 128'(0));
        chk({tag, "_m_wdata"}, 128'(m_write_data), 128'(0));
        chk({tag, "_s_rvalid"}, 128'(s_read_data_valid), 128'(0));
        chk({tag, "_s_rdata"}, 128'(s_read_data), 128'(0));
        chk({tag, "_m_resp_ready"}, 128'(m_resp_ready), 128'(1));
`ifdef AVL_PIPE_STATS_EN
        chk({tag, "_stat_rd"}, 128'(stat_rd_beats), 128'(0));
        chk({tag, "_stat_wr"}, 128'(stat_wr_beats), 128'(0));
`endif
    endtask

    initial begin
        int idx;
        int seen;

        vecs[0] = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b1, 32'hA1};
        vecs[1] = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[2] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[3] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[4] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[5] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[6] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA2};
        vecs[7] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA3};
        vecs[8] = '{1'b0, 32'hA3, 1'b1, 1'b1, 1'b0, 32'hA3};

        rst = 1;
        s_address = 0; s_byte_en = 0; s_read = 0; s_write = 0; s_write_data = 0;
        s_begin_burst_transfer = 0; s_burst_count = 0; s_resp_ready = 0;
        m_request_ready = 0; m_read_data = 0; m_read_data_valid = 0;

        #12;
        check_reset_values("reset");
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;

        // 1: single write appears one cycle later
        s_write = 1; s_address = 32'h10; s_write_data = 32'hDEADBEEF;
        s_byte_en = 4'hF; s_burst_count = 8'd1; s_begin_burst_transfer = 1;
        m_request_ready = 1;
        @(posedge clk); #1;
        chk("t1_m_write", 128'(m_write), 128'(1));
        chk("t1_m_address", 128'(m_address), 128'(32'h10));
        chk("t1_m_wdata", 128'(m_write_data), 128'(32'hDEADBEEF));
        chk("t1_s_ready", 128'(s_request_ready), 128'(1));
        #1;
        idle_inputs();
        @(posedge clk); #1;
        chk("t1_m_write_done", 128'(m_write), 128'(0));
        #1;

        // 2: back-to-back writes with a 5-cycle slave stall
        s_address = 32'h100;
        for (int i = 0; i < 9; i++) begin
            s_write = vecs[i].s_wr;
            s_write_data = vecs[i].wdata;
            m_request_ready = vecs[i].m_rdy;
            @(posedge clk); #1;
            chk($sformatf("t2_v%0d_s_ready", i), 128'(s_request_ready), 128'(vecs[i].exp_s_rdy));
            chk($sformatf("t2_v%0d_m_write", i), 128'(m_write), 128'(vecs[i].exp_m_wr));
            chk($sformatf("t2_v%0d_m_wdata", i), 128'(m_write_data), 128'(vecs[i].exp_m_data));
            #1;
        end
        idle_inputs();

        // 3: 8-beat read burst with the master not taking responses
        delivered_q.delete();
        s_resp_ready = 0;
        s_read = 1; s_address = 32'h200; s_burst_count = 8'd8; s_begin_burst_transfer = 1;
        @(posedge clk); #1;
        chk("t3_m_read", 128'(m_read), 128'(1));
        chk("t3_m_burst", 128'(m_burst_count), 128'(8));
        chk("t3_m_bb", 128'(m_begin_burst_transfer), 128'(1));
        #1;
        idle_inputs();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_resp_ready && idx < 8) begin
                m_read_data_valid = 1; m_read_data = 32'hA000_0000 + idx; idx++;
            end else begin
                m_read_data_valid = 0;
            end
            @(posedge clk); #2;
        end
        chk("t3_beats_before_full", 128'(idx), 128'(4));
        chk("t3_m_resp_ready_full", 128'(m_resp_ready), 128'(0));
        s_resp_ready = 1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            if (m_resp_ready) begin
                m_read_data_valid = 1; m_read_data = 32'hA000_0000 + idx; idx++;
            end else begin
                m_read_data_valid = 0;
            end
            @(posedge clk); #2;
        end
        m_read_data_valid = 0;
        repeat (8) @(posedge clk);
        #2;
        chk("t3_delivered", 128'(delivered_q.size()), 128'(8));
        for (int i = 0; i < 8 && i < delivered_q.size(); i++)
            chk($sformatf("t3_word%0d", i), 128'(delivered_q[i]), 128'(32'hA000_0000 + i));

        // 4: simultaneous push and pop at count 2
        delivered_q.delete();
        s_resp_ready = 0;
        m_read_data_valid = 1; m_read_data = 32'hC0;
        @(posedge clk); #2;
        m_read_data = 32'hC1;
        @(posedge clk); #2;
        m_read_data = 32'hC2; s_resp_ready = 1;
        @(posedge clk); #1;
        chk("t4_head", 128'(s_read_data), 128'(32'hC1));
        chk("t4_valid", 128'(s_read_data_valid), 128'(1));
        #1;
        m_read_data_valid = 0; s_resp_ready = 0;
        @(posedge clk); #2;
        chk("t4_popped", 128'(delivered_q.size()), 128'(1));
        s_resp_ready = 1;
        repeat (5) @(posedge clk);
        #2;
        chk("t4_delivered", 128'(delivered_q.size()), 128'(3));
        if (delivered_q.size() == 3) begin
            chk("t4_w0", 128'(delivered_q[0]), 128'(32'hC0));
            chk("t4_w1", 128'(delivered_q[1]), 128'(32'hC1));
            chk("t4_w2", 128'(delivered_q[2]), 128'(32'hC2));
        end

        // Randomized traffic, checked by the monitor model
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 3);
            s_read = (r == 1);
            s_write = (r >= 2);
            s_address = $urandom;
            s_byte_en = 4'($urandom);
            s_write_data = $urandom;
            s_begin_burst_transfer = 1'($urandom);
            s_burst_count = 8'($urandom);
            m_request_ready = ($urandom_range(0, 3) != 0);
            m_read_data_valid = 1'($urandom);
            m_read_data = $urandom;
            s_resp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #2;
        end
        idle_inputs();
        m_request_ready = 1; s_resp_ready = 1;
        repeat (10) @(posedge clk);
        #2;
        chk("rand_req_drained", 128'(req_q.size()), 128'(0));
        chk("rand_resp_drained", 128'(resp_q.size()), 128'(0));

        // 5: async reset with two requests buffered and three responses queued
        m_request_ready = 0; s_resp_ready = 0;
        s_write = 1; s_write_data = 32'hB1; s_burst_count = 8'd2; s_begin_burst_transfer = 1;
        m_read_data_valid = 1; m_read_data = 32'hD0;
        @(posedge clk); #2;
        s_write_data = 32'hB2; s_begin_burst_transfer = 0; m_read_data = 32'hD1;
        @(posedge clk); #2;
        s_write = 0; m_read_data = 32'hD2;
        @(posedge clk); #2;
        idle_inputs();
        chk("t5_pre_s_ready", 128'(s_request_ready), 128'(0));
        chk("t5_pre_m_write", 128'(m_write), 128'(1));
        chk("t5_pre_rvalid", 128'(s_read_data_valid), 128'(1));
        #1;
        rst = 1;
        #1;
        check_reset_values("t5_async");
        @(posedge clk);
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #1;
        chk("t5_post_s_ready", 128'(s_request_ready), 128'(1));
        chk("t5_post_m_write", 128'(m_write), 128'(0));
        chk("t5_post_rvalid", 128'(s_read_data_valid), 128'(0));
        #1;

`ifdef AVL_PIPE_STATS_EN
        // 6: three reads then a 4-beat write burst
        m_request_ready = 1; s_resp_ready = 1;
        s_burst_count = 8'd1; s_begin_burst_transfer = 1;
        for (int i = 0; i < 3; i++) begin
            s_read = 1; s_address = 32'h300 + 32'(i * 4);
            @(posedge clk); #2;
        end
        s_read = 0; s_write = 1; s_burst_count = 8'd4;
        for (int i = 0; i < 4; i++) begin
            s_begin_burst_transfer = (i == 0);
            s_write_data = 32'hE0 + 32'(i);
            @(posedge clk); #2;
        end
        idle_inputs();
        repeat (4) @(posedge clk);
        #2;
        chk("t6_stat_rd", 128'(stat_rd_beats), 128'(3));
        chk("t6_stat_wr", 128'(stat_wr_beats), 128'(4));
`endif

        seen = checks;
        $display("Result: errors=%0d of %0d checks", errors, seen);
        $finish;
    end

endmodule
